// File: rtl/noc_inject_arbiter.sv
// Injection arbiter: shares one router local input port among NUM_REQ tile requesters,
// packet-at-a-time, with starvation promotion, priority bypass and round-robin fairness.
module noc_inject_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int FLIT_WIDTH   = 64,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_pri,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          noc_req_out,
    output logic [FLIT_WIDTH-1:0]         noc_flit_out,
    input  logic                          noc_ack_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [CW-1:0]  STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

    // First set bit of mask searching upward from ptr, wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] sel;
        logic           found;
        logic [IDW-1:0] idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic [IDW-1:0]        rr_ptr_r;
    logic [IDW-1:0]        grant_id_r;
    logic                  last_r;
    logic                  noc_req_r;
    logic                  busy_r;
    logic [FLIT_WIDTH-1:0] flit_r;
    logic [CW-1:0]         wait_cnt_r [NUM_REQ];

    logic [NUM_REQ-1:0]    starve_mask_s;
    logic [NUM_REQ-1:0]    pri_mask_s;
    logic [IDW-1:0]        winner_s;
    logic [IDW-1:0]        sel_s;
    logic [NUM_REQ-1:0]    ready_s;

    // Class masks for winner selection.
    always_comb begin
        starve_mask_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_mask_s[i] = req_valid[i] && (wait_cnt_r[i] == STARVE_MAX);
        end
        pri_mask_s = req_valid & req_pri;
    end

    // Winner: first non-empty class among starving, high priority, any valid.
    always_comb begin
        winner_s = '0;
        if (|starve_mask_s) begin
            winner_s = rr_pick(starve_mask_s, rr_ptr_r);
        end else if (|pri_mask_s) begin
            winner_s = rr_pick(pri_mask_s, rr_ptr_r);
        end else begin
            winner_s = rr_pick(req_valid, rr_ptr_r);
        end
    end

    // Next state and the one-cycle capture pulse.
    always_comb begin
        state_next_s = state_r;
        ready_s      = '0;
        sel_s        = grant_id_r;
        case (state_r)
            ST_IDLE: begin
                sel_s = winner_s;
                if (|req_valid) begin
                    ready_s[winner_s] = 1'b1;
                    state_next_s      = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (noc_ack_in) begin
                    state_next_s = last_r ? ST_IDLE : ST_BODY;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_BODY: begin
                if (req_valid[grant_id_r]) begin
                    ready_s[grant_id_r] = 1'b1;
                    state_next_s        = ST_SEND;
                end else begin
                    state_next_s = ST_BODY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Packet FSM, output registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            last_r     <= 1'b0;
            noc_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            flit_r     <= '0;
        end else begin
            state_r   <= state_next_s;
            noc_req_r <= (state_next_s == ST_SEND);
            busy_r    <= (state_next_s != ST_IDLE);
            if (|ready_s) begin
                flit_r     <= req_flit[int'(sel_s)*FLIT_WIDTH +: FLIT_WIDTH];
                last_r     <= req_last[sel_s];
                grant_id_r <= sel_s;
            end else begin
                flit_r     <= flit_r;
                last_r     <= last_r;
                grant_id_r <= grant_id_r;
            end
            if ((state_r == ST_SEND) && noc_ack_in && last_r) begin
                rr_ptr_r <= (grant_id_r == LAST_ID) ? '0 : grant_id_r + IDW'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Wait counters: the packet owner and idle requesters stay at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || ready_s[i] || (busy_r && (grant_id_r == IDW'(i)))) begin
                    wait_cnt_r[i] <= '0;
                end else if (wait_cnt_r[i] != STARVE_MAX) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + CW'(1);
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
        end
    end

    // The capture pulse is masked during reset so nothing is taken while the FSM is held.
    assign req_ready    = rst_n ? ready_s : '0;
    assign noc_req_out  = noc_req_r;
    assign noc_flit_out = flit_r;
    assign grant_id     = grant_id_r;
    assign busy         = busy_r;

endmodule
